// File: rtl/bcd_display_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bcd_display_sequencer                                        |
// | Description : Double-dabble binary-to-BCD converter feeding a scrollable   |
// |               three-digit window over a five-digit signed result.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bcd_display_sequencer #(
    parameter int PRODUCT_W    = 14,
    parameter int SHIFT_CYCLES = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [PRODUCT_W-1:0] product,
    input  logic                 negIn,
    input  logic                 scrollLeft,
    input  logic                 scrollRight,
    output logic [3:0]           segBCD3,
    output logic [3:0]           segBCD2,
    output logic [3:0]           segBCD1,
    output logic                 negativeProductFlag,
    output logic                 busy,
    output logic                 done
);

    localparam int         c_BCD_W = 20;
    localparam int         c_CNT_W = $clog2(SHIFT_CYCLES + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_SHOW  = 2'd2;

    logic [1:0]           r_state_q,  r_state_d;
    logic [PRODUCT_W-1:0] r_bin_q,    r_bin_d;
    logic [c_BCD_W-1:0]   r_bcd_q,    r_bcd_d;
    logic [c_CNT_W-1:0]   r_cnt_q,    r_cnt_d;
    logic                 r_sign_q,   r_sign_d;
    logic [c_BCD_W-1:0]   r_result_q, r_result_d;
    logic [1:0]           r_pos_q,    r_pos_d;
    logic                 r_neg_q,    r_neg_d;
    logic                 r_busy_q,   r_busy_d;
    logic                 r_done_q,   r_done_d;

    logic [c_BCD_W-1:0]   w_bcd_adj;
    logic [11:0]          w_window;

    always_comb begin
        w_bcd_adj = r_bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd_q[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        r_state_d  = r_state_q;
        r_bin_d    = r_bin_q;
        r_bcd_d    = r_bcd_q;
        r_cnt_d    = r_cnt_q;
        r_sign_d   = r_sign_q;
        r_result_d = r_result_q;
        r_pos_d    = r_pos_q;
        r_neg_d    = r_neg_q;
        r_busy_d   = 1'b0;
        r_done_d   = 1'b0;
        case (r_state_q)
            c_IDLE, c_SHOW: begin
                if (start) begin
                    r_bin_d   = product;
                    r_bcd_d   = '0;
                    r_cnt_d   = '0;
                    r_sign_d  = negIn & (|product);
                    r_state_d = c_SHIFT;
                end else if (r_state_q == c_SHOW) begin
                    // Simultaneous left+right cancels out.
                    if (scrollLeft && !scrollRight && r_pos_q != 2'd2) begin
                        r_pos_d = r_pos_q + 2'd1;
                    end else if (scrollRight && !scrollLeft && r_pos_q != 2'd0) begin
                        r_pos_d = r_pos_q - 2'd1;
                    end
                end
            end
            c_SHIFT: begin
                if (r_cnt_q == c_CNT_W'(SHIFT_CYCLES)) begin
                    r_result_d = r_bcd_q;
                    r_pos_d    = 2'd0;
                    r_neg_d    = r_sign_q;
                    r_done_d   = 1'b1;
                    r_state_d  = c_SHOW;
                end else begin
                    {r_bcd_d, r_bin_d} = {w_bcd_adj, r_bin_q} << 1;
                    r_cnt_d            = r_cnt_q + c_CNT_W'(1);
                    r_busy_d           = 1'b1;
                end
            end
            default: r_state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= c_IDLE;
            r_bin_q    <= '0;
            r_bcd_q    <= '0;
            r_cnt_q    <= '0;
            r_sign_q   <= 1'b0;
            r_result_q <= '0;
            r_pos_q    <= 2'd0;
            r_neg_q    <= 1'b0;
            r_busy_q   <= 1'b0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_bin_q    <= r_bin_d;
            r_bcd_q    <= r_bcd_d;
            r_cnt_q    <= r_cnt_d;
            r_sign_q   <= r_sign_d;
            r_result_q <= r_result_d;
            r_pos_q    <= r_pos_d;
            r_neg_q    <= r_neg_d;
            r_busy_q   <= r_busy_d;
            r_done_q   <= r_done_d;
        end
    end

    always_comb begin
        case (r_pos_q)
            2'd1:    w_window = r_result_q[15:4];
            2'd2:    w_window = r_result_q[19:8];
            default: w_window = r_result_q[11:0];
        endcase
    end

    assign segBCD3             = w_window[11:8];
    assign segBCD2             = w_window[7:4];
    assign segBCD1             = w_window[3:0];
    assign negativeProductFlag = r_neg_q;
    assign busy                = r_busy_q;
    assign done                = r_done_q;

endmodule
`default_nettype wire

// File: doc/bcd_display_sequencer.md
BCD_DISPLAY_SEQUENCER -- requirements
Module: bcd_display_sequencer

Interface
REQ-001 SHALL have parameter PRODUCT_W, default 14, product magnitude width; the design is verified at 14 only.
REQ-002 SHALL have parameter SHIFT_CYCLES, default 14, number of double-dabble iterations; always equal to PRODUCT_W.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to convert product.
- product  in  14  unsigned product magnitude.
- negIn  in  1  sign of the product (1 = negative).
- scrollLeft  in  1  single-cycle pulse, already debounced.
- scrollRight  in  1  single-cycle pulse, already debounced.
- segBCD3  out  4  leftmost displayed digit.
- segBCD2  out  4  middle displayed digit.
- segBCD1  out  4  rightmost displayed digit.
- negativeProductFlag  out  1  registered sign for the display.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when a new result is presented.

Function
REQ-004 SHALL implement FSM states IDLE, SHIFT and SHOW.
REQ-005 SHALL accept start only in IDLE or SHOW.
- Acceptance edge T: capture product into a 14-bit shift register, clear a 20-bit BCD accumulator (5 digits) and the iteration counter, capture negIn, enter SHIFT.
REQ-006 SHALL, in SHIFT, perform one double-dabble iteration per cycle.
- Each iteration: add 3 to every BCD digit >= 5, then shift {BCD, binary} left by 1.
- Counter increments 0..13.
REQ-007 SHALL leave SHIFT after exactly 14 iterations (edges T+1..T+14).
- At edge T+15: latch all 5 digits into a result register, reset the scroll position to 0, update negativeProductFlag, enter SHOW.
REQ-008 SHALL assert done for exactly the one cycle following edge T+15.
REQ-009 SHALL drive busy high from edge T+1 through the cycle in which the results are latched; busy is low otherwise.
REQ-010 SHALL ignore start while in SHIFT; the conversion in flight completes unaltered.
REQ-011 SHALL hold segBCD3..1 and negativeProductFlag at their previous values throughout SHIFT; no partial digits are ever visible.
REQ-012 SHALL set negativeProductFlag = captured sign AND (product != 0); -0 is never shown.
REQ-013 SHALL map digits D4..D0 (D0 = units) to outputs by scroll position P:
- P=0: {D2,D1,D0}.
- P=1: {D3,D2,D1}.
- P=2: {D4,D3,D2}.
- Outputs map in the order segBCD3, segBCD2, segBCD1.
REQ-014 SHALL update P only in SHOW.
- scrollLeft: P+1, saturating at 2.
- scrollRight: P-1, saturating at 0.
- Both asserted in the same cycle: P unchanged.
- Scroll pulses in IDLE or SHIFT are ignored.
REQ-015 SHALL give start priority when start and a scroll pulse arrive together in SHOW; the scroll pulse is dropped.
REQ-016 SHALL apply a P change at the next edge; outputs reflect the new window one cycle after the pulse.
REQ-017 SHALL never produce a digit value above 9 for any product in 0..16383.

Reset
REQ-018 SHALL, on rst high at a rising edge, regardless of state (including mid-SHIFT):
- Go to IDLE.
- Set P=0.
- Clear the result register, so segBCD3..1 = 0.
- Set negativeProductFlag=0, busy=0, done=0.
- Abandon any in-flight conversion with no done pulse.
REQ-019 SHALL give rst priority over start and over the scroll inputs in the same cycle.

Verification
REQ-020 product=1234, negIn=0, start -> done exactly 15 cycles after the acceptance edge; outputs 2,3,4; flag 0; busy high for those cycles.
REQ-021 after REQ-020: scrollLeft x3 -> 1,2,3, then 0,1,2, then 0,1,2 (saturated); scrollRight x3 -> 1,2,3, then 2,3,4, then 2,3,4 (saturated).
REQ-022 product=16383, negIn=1 -> P0 shows 3,8,3; P2 shows 1,6,3; flag 1. Then product=0, negIn=1 -> 0,0,0, flag 0, P reset to 0.
REQ-023 start with product=500, then a second start with product=77 at cycle T+5 -> second start ignored; result 5,0,0; single done pulse.
REQ-024 rst asserted at T+8 of a conversion -> next cycle IDLE, outputs 0, busy 0, no done; a fresh start converts correctly.
REQ-025 scrollLeft and scrollRight high together in SHOW -> P unchanged; start together with scrollLeft in SHOW -> conversion starts, P=0 after done.
